// File: rtl/agh_io_pkg.sv
// Shared constants and types for the AGH I/O bank: ID word, register map
// offsets, channel stride, mode and Avalon response encodings.
package agh_io_pkg;

  localparam logic [31:0] ID_VALUE = 32'h4147_4901;

  // Word indices (byte address bits [11:2])
  localparam logic [9:0] IDX_ID  = 10'h000;
  localparam logic [9:0] IDX_CFG = 10'h001;
  localparam logic [9:0] CH_BASE = 10'h010;

  localparam int unsigned CH_STRIDE = 4;

  // Offsets within a channel block
  localparam logic [1:0] OFF_VALUE  = 2'd0;
  localparam logic [1:0] OFF_MODE   = 2'd1;
  localparam logic [1:0] OFF_PERIOD = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  typedef enum logic {
    MODE_STATIC = 1'b0,
    MODE_BLINK  = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  // Merge write data into the current register word, lane by lane
  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/agh_io_blink.sv
// Per-channel blink timer: counts up to period-1, then toggles phase.
// Held at counter 0 / phase 1 when static, when period is 0, or on restart.
module agh_io_blink #(
  parameter int unsigned PRESC_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode_blink,
  input  logic [PRESC_W-1:0] period,
  input  logic               restart,
  output logic               phase
);

  logic [PRESC_W-1:0] cnt_q;

  // Counter and phase; >= guards against ever running past period-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      phase <= 1'b1;
    end else if (restart || !mode_blink || period == '0) begin
      cnt_q <= '0;
      phase <= 1'b1;
    end else if (cnt_q >= period - PRESC_W'(1)) begin
      cnt_q <= '0;
      phase <= ~phase;
    end else begin
      cnt_q <= cnt_q + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/agh_io_bank.sv
// Avalon-MM register bank driving N_CH output channels, each either a
// static value or a value gated by a programmable blink timer.
module agh_io_bank
  import agh_io_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PRESC_W = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [11:0]            avs_s0_address,
  input  logic                   avs_s0_read,
  input  logic                   avs_s0_write,
  input  logic [3:0]             avs_s0_byteenable,
  input  logic [31:0]            avs_s0_writedata,
  output logic                   avs_s0_waitrequest,
  output logic [31:0]            avs_s0_readdata,
  output logic                   avs_s0_readdatavalid,
  output logic                   avs_s0_writeresponsevalid,
  output logic [1:0]             avs_s0_response,
  output logic [N_CH*DATA_W-1:0] out
);

  localparam int unsigned CH_SPAN = N_CH * CH_STRIDE;

  logic [9:0]         idx;
  logic [9:0]         rel;
  logic [7:0]         ch_sel;
  logic [1:0]         off;
  logic               is_ch;

  logic [DATA_W-1:0]  value_q  [N_CH];
  mode_e              mode_q   [N_CH];
  logic [PRESC_W-1:0] period_q [N_CH];
  logic [N_CH-1:0]    phase;
  logic [N_CH-1:0]    restart;

  logic [31:0]        rd_data;
  logic [31:0]        wr_word;
  resp_e              rd_resp;
  resp_e              wr_resp;
  logic               unused_ok;

  assign idx    = avs_s0_address[11:2];
  assign rel    = idx - CH_BASE;
  assign ch_sel = rel[9:2];
  assign off    = rel[1:0];
  assign is_ch  = (idx >= CH_BASE) && (32'(rel) < CH_SPAN);

  assign avs_s0_waitrequest = 1'b0;
  assign unused_ok          = ^{avs_s0_address[1:0], wr_word};

  // Address decode, read mux, per-access response and write-merge word
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_DECERR;
    wr_resp = RESP_DECERR;
    restart = '0;
    if (idx == IDX_ID) begin
      rd_data = ID_VALUE;
      rd_resp = RESP_OKAY;
      wr_resp = RESP_SLVERR;
    end else if (idx == IDX_CFG) begin
      rd_data = {16'b0, 8'(DATA_W), 8'(N_CH)};
      rd_resp = RESP_OKAY;
      wr_resp = RESP_SLVERR;
    end else if (is_ch) begin
      rd_resp = RESP_OKAY;
      wr_resp = (off == OFF_STATUS) ? RESP_SLVERR : RESP_OKAY;
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        if (ch_sel == 8'(ch)) begin
          case (off)
            OFF_VALUE:  rd_data = 32'(value_q[ch]);
            OFF_MODE:   rd_data = {31'b0, mode_q[ch]};
            OFF_PERIOD: rd_data = 32'(period_q[ch]);
            default:    rd_data = {31'b0, phase[ch]};
          endcase
          restart[ch] = avs_s0_write && (|avs_s0_byteenable) &&
                        (off == OFF_MODE || off == OFF_PERIOD);
        end
      end
    end
    // rd_data is the stored word zero-extended, so merging into it keeps
    // untouched lanes and the truncation below drops unimplemented bits
    wr_word = be_merge(rd_data, avs_s0_writedata, avs_s0_byteenable);
  end

  // Register file writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        value_q[ch]  <= '0;
        mode_q[ch]   <= MODE_STATIC;
        period_q[ch] <= '0;
      end
    end else if (avs_s0_write && is_ch && (|avs_s0_byteenable)) begin
      for (int unsigned ch = 0; ch < N_CH; ch++) begin
        if (ch_sel == 8'(ch)) begin
          case (off)
            OFF_VALUE:  value_q[ch]  <= wr_word[DATA_W-1:0];
            OFF_MODE:   mode_q[ch]   <= mode_e'(wr_word[0]);
            OFF_PERIOD: period_q[ch] <= wr_word[PRESC_W-1:0];
            default: ;
          endcase
        end
      end
    end
  end

  // Completion strobes, response and registered read data; write wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avs_s0_readdata           <= '0;
      avs_s0_readdatavalid      <= 1'b0;
      avs_s0_writeresponsevalid <= 1'b0;
      avs_s0_response           <= RESP_OKAY;
    end else begin
      avs_s0_readdatavalid      <= avs_s0_read && !avs_s0_write;
      avs_s0_writeresponsevalid <= avs_s0_write;
      if (avs_s0_write) begin
        avs_s0_response <= wr_resp;
      end else if (avs_s0_read) begin
        avs_s0_response <= rd_resp;
        avs_s0_readdata <= rd_data;
      end else begin
        avs_s0_response <= RESP_OKAY;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    agh_io_blink #(
      .PRESC_W (PRESC_W)
    ) u_blink (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode_blink (mode_q[g] == MODE_BLINK),
      .period     (period_q[g]),
      .restart    (restart[g]),
      .phase      (phase[g])
    );

    // Static mode holds phase at 1, so one gate covers both modes
    assign out[g*DATA_W +: DATA_W] = phase[g] ? value_q[g] : '0;
  end

endmodule

// File: tb/tb_agh_io_bank.sv
// Directed self-checking bench for agh_io_bank (N_CH=4, DATA_W=8, PRESC_W=24).
module tb_agh_io_bank;

  logic        clk;
  logic        rst_n;
  logic [11:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        writeresponsevalid;
  logic [1:0]  response;
  logic [31:0] out;

  int ntests = 0;
  int nfail  = 0;

  agh_io_bank #(
    .N_CH    (4),
    .DATA_W  (8),
    .PRESC_W (24)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .avs_s0_address            (address),
    .avs_s0_read               (read),
    .avs_s0_write              (write),
    .avs_s0_byteenable         (byteenable),
    .avs_s0_writedata          (writedata),
    .avs_s0_waitrequest        (waitrequest),
    .avs_s0_readdata           (readdata),
    .avs_s0_readdatavalid      (readdatavalid),
    .avs_s0_writeresponsevalid (writeresponsevalid),
    .avs_s0_response           (response),
    .out                       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input string tag, input logic [11:0] a,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    @(negedge clk);
    address = a; read = 1'b1; write = 1'b0;
    @(posedge clk); #1;
    read = 1'b0;
    chk({tag, ".rdv"},  {31'b0, readdatavalid}, 32'd1);
    chk({tag, ".wrv"},  {31'b0, writeresponsevalid}, 32'd0);
    chk({tag, ".data"}, readdata, exp_data);
    chk({tag, ".resp"}, {30'b0, response}, {30'b0, exp_resp});
  endtask

  task automatic do_write(input string tag, input logic [11:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic [1:0] exp_resp);
    @(negedge clk);
    address = a; writedata = d; byteenable = be; write = 1'b1; read = 1'b0;
    @(posedge clk); #1;
    write = 1'b0;
    chk({tag, ".wrv"},  {31'b0, writeresponsevalid}, 32'd1);
    chk({tag, ".rdv"},  {31'b0, readdatavalid}, 32'd0);
    chk({tag, ".resp"}, {30'b0, response}, {30'b0, exp_resp});
  endtask

  initial begin
    rst_n = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0; byteenable = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.out",  out, 32'h0);
    chk("rst.rdv",  {31'b0, readdatavalid}, 32'd0);
    chk("rst.wrv",  {31'b0, writeresponsevalid}, 32'd0);
    chk("rst.data", readdata, 32'h0);
    chk("rst.resp", {30'b0, response}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ID and CFG, first transaction right after release
    do_read("id",  12'h000, 32'h4147_4901, 2'b00);
    do_read("cfg", 12'h004, 32'h0000_0804, 2'b00);
    @(posedge clk); #1;
    chk("idle.rdv", {31'b0, readdatavalid}, 32'd0);

    // Byte-enable handling on ch1 VALUE
    do_write("ch1v.a5", 12'h050, 32'h0000_00A5, 4'b0001, 2'b00);
    chk("ch1v.out", {24'h0, out[15:8]}, 32'hA5);
    do_write("ch1v.be0", 12'h050, 32'h0000_00FF, 4'b0000, 2'b00);
    chk("ch1v.hold", {24'h0, out[15:8]}, 32'hA5);
    do_write("ch1v.lane1", 12'h050, 32'h0000_3300, 4'b0010, 2'b00);
    do_read("ch1v.rd", 12'h050, 32'h0000_00A5, 2'b00);

    // Upper bits stored as zero
    do_write("ch3v", 12'h070, 32'hDEAD_BE5A, 4'b1111, 2'b00);
    do_read("ch3v.rd", 12'h070, 32'h0000_005A, 2'b00);
    chk("ch3v.out", {24'h0, out[31:24]}, 32'h5A);
    do_write("ch0p.wide", 12'h048, 32'hFFFF_FFFF, 4'b1111, 2'b00);
    do_read("ch0p.rd", 12'h048, 32'h00FF_FFFF, 2'b00);
    do_write("ch0m.wide", 12'h044, 32'hFFFF_FFFE, 4'b1111, 2'b00);
    do_read("ch0m.rd", 12'h044, 32'h0000_0000, 2'b00);

    // ch0 blink, period 3: 3 cycles on, 3 off
    do_write("ch0v", 12'h040, 32'h0000_000F, 4'b0001, 2'b00);
    do_write("ch0p", 12'h048, 32'h0000_0003, 4'b1111, 2'b00);
    do_write("ch0m", 12'h044, 32'h0000_0001, 4'b0001, 2'b00);
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("blink.k%0d", k), {24'h0, out[7:0]},
          (((k / 3) % 2) == 0) ? 32'h0F : 32'h00);
      @(posedge clk); #1;
    end

    // Restart via MODE write, then STATUS follows phase
    do_write("ch0m.re", 12'h044, 32'h0000_0001, 4'b0001, 2'b00);
    do_read("stat0", 12'h04C, 32'h1, 2'b00);
    do_read("stat1", 12'h04C, 32'h1, 2'b00);
    do_read("stat2", 12'h04C, 32'h1, 2'b00);
    do_read("stat3", 12'h04C, 32'h0, 2'b00);
    chk("mid.off", {24'h0, out[7:0]}, 32'h00);

    // PERIOD rewrite mid-phase restarts with phase 1
    do_write("ch0p.re", 12'h048, 32'h0000_0003, 4'b0001, 2'b00);
    chk("mid.on", {24'h0, out[7:0]}, 32'h0F);

    // PERIOD 0 in blink mode: constant VALUE
    do_write("ch0p.z", 12'h048, 32'h0000_0000, 4'b1111, 2'b00);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("p0.k%0d", k), {24'h0, out[7:0]}, 32'h0F);
      @(posedge clk); #1;
    end

    // Decode and slave errors
    do_read("ch4", 12'h080, 32'h0, 2'b11);
    do_write("ch4.w", 12'h080, 32'h1234_5678, 4'b1111, 2'b11);
    do_write("stat.w", 12'h04C, 32'h0000_0000, 4'b1111, 2'b10);
    do_read("stat.rd", 12'h04C, 32'h1, 2'b00);
    do_write("id.w", 12'h000, 32'h0, 4'b1111, 2'b10);
    do_read("id.rd2", 12'h000, 32'h4147_4901, 2'b00);

    // Simultaneous read and write: write wins, no read completion
    @(negedge clk);
    address = 12'h060; writedata = 32'h0000_003C; byteenable = 4'b0001;
    read = 1'b1; write = 1'b1;
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    chk("rw.wrv",  {31'b0, writeresponsevalid}, 32'd1);
    chk("rw.rdv",  {31'b0, readdatavalid}, 32'd0);
    chk("rw.resp", {30'b0, response}, 32'd0);
    chk("rw.out",  {24'h0, out[23:16]}, 32'h3C);

    // Reset while a read is pending: dropped, everything cleared
    @(negedge clk);
    address = 12'h000; read = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rstrd.out", out, 32'h0);
    @(posedge clk); #1;
    read = 1'b0;
    chk("rstrd.rdv", {31'b0, readdatavalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rstrd.rdv%0d", k), {31'b0, readdatavalid}, 32'd0);
    end
    do_read("post.ch1", 12'h050, 32'h0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/agh_io_bank.md
AGH_IO_BANK -- requirements
Module: agh_io_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of output channels (1..8).
REQ-002 SHALL have parameter DATA_W, default 8, bits per channel (1..32).
REQ-003 SHALL have parameter PRESC_W, default 24, blink period counter width (1..32).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 avs_s0_address  input  12  byte address; word index is bits [11:2].
REQ-007 avs_s0_read, avs_s0_write  input  1 each  Avalon-MM read and write strobes.
REQ-008 avs_s0_byteenable  input  4  byte lanes for writes.
REQ-009 avs_s0_writedata  input  32  write data.
REQ-010 avs_s0_waitrequest  output  1  stall; always 0 (no back-pressure).
REQ-011 avs_s0_readdata  output  32  registered read data.
REQ-012 avs_s0_readdatavalid, avs_s0_writeresponsevalid  output  1 each  completion strobes.
REQ-013 avs_s0_response  output  2  00 OKAY, 10 SLVERR, 11 DECODEERROR; valid with either strobe.
REQ-014 out  output  N_CH*DATA_W  channel outputs, channel ch at bits [ch*DATA_W +: DATA_W].

Function
REQ-015 Register map (word index): 0x000 ID RO = 0x4147_4901; 0x001 CFG RO = {16'b0, DATA_W[7:0], N_CH[7:0]}; channel ch at base 0x010+4*ch: +0 VALUE RW, +1 MODE RW [0], +2 PERIOD RW, +3 STATUS RO [0] = phase.
REQ-016 Read accepted in cycle N; readdata, readdatavalid=1 and response SHALL appear in cycle N+1; latency exactly 1.
REQ-017 Write accepted in cycle N; register updates at end of cycle N; writeresponsevalid=1 with response in cycle N+1.
REQ-018 Read and write asserted together: write SHALL proceed; read ignored, no readdatavalid.
REQ-019 Unmapped index (including channels >= N_CH): read returns 0 with DECODEERROR; write has no effect, DECODEERROR.
REQ-020 Write to ID, CFG or STATUS: no effect, SLVERR.
REQ-021 RW writes SHALL honour byteenable per lane; byteenable=0 -> OKAY, no change.
REQ-022 Register bits above DATA_W (VALUE) or PRESC_W (PERIOD), and MODE[31:1], SHALL be stored as 0 and read as 0.
REQ-023 MODE=0 STATIC: out channel = VALUE, combinational from the register (visible in cycle N+1 after write).
REQ-024 MODE=1 BLINK: counter increments every cycle; when counter == PERIOD-1, counter -> 0 and phase toggles; out channel = phase ? VALUE : 0.
REQ-025 BLINK with PERIOD=0: counter held 0, phase held 1, out = VALUE.
REQ-026 Any accepted write to a channel's MODE or PERIOD (nonzero byteenable) SHALL clear its counter to 0 and set phase to 1 in the same clock edge.
REQ-027 In STATIC mode, counter held 0 and phase held 1.
REQ-028 Counter SHALL never wrap past PERIOD-1; with PERIOD = 2^PRESC_W-1 it reaches the maximum without overflow.

Reset
REQ-029 On rst_n low, asynchronously: all VALUE, MODE, PERIOD = 0; counters 0; phase 1; readdata 0; readdatavalid 0; writeresponsevalid 0; response 00; out = 0.
REQ-030 Transaction in flight when reset asserts SHALL be dropped; no completion strobe after release.
REQ-031 First transaction SHALL be accepted in the first cycle after rst_n rises.

Structure
REQ-032 Package agh_io_pkg SHALL hold ID constant, register offsets, channel stride, mode enum, response enum.
REQ-033 Per-channel counter/phase logic SHALL be sub-module agh_io_blink, instantiated N_CH times by a generate loop.
REQ-034 Address decode, register file and read mux SHALL remain in agh_io_bank.

Verification
REQ-035 Reset, read 0x000 and 0x001 (N_CH=4, DATA_W=8) -> 0x4147_4901 OKAY, 0x0000_0804 OKAY, each one cycle after accept.
REQ-036 Write 0xA5 to ch1 VALUE, byteenable=0001 -> out[15:8]=0xA5; rewrite 0xFF with byteenable=0000 -> stays 0xA5, OKAY.
REQ-037 ch0 PERIOD=3, MODE=1, VALUE=0x0F -> out[7:0] 0x0F for 3 cycles, 0x00 for 3, repeating; STATUS tracks phase.
REQ-038 Rewrite PERIOD mid-phase -> counter 0, phase 1, out=VALUE next cycle; PERIOD=0 in BLINK -> out constant VALUE.
REQ-039 Read 0x020 (ch4, N_CH=4) -> 0, DECODEERROR; write 0x013 -> SLVERR, STATUS unchanged.
REQ-040 Simultaneous read+write to ch2 VALUE -> write applied, writeresponsevalid only; reset asserted during read -> no readdatavalid.
